// File: rtl/rx_sampler_if.sv
// Bundle between the UART receive sampler and the Rx FSM/datapath it feeds.
// The raw line enters here and the per-bit strobe stream leaves here.
interface rx_sampler_if;
    logic serial_in;
    logic start_detected;
    logic sampling_strobe;
    logic sampled_bit;
    logic noise_flag;
    logic false_start;
    logic busy;

    modport master (
        input  serial_in,
        output start_detected,
        output sampling_strobe,
        output sampled_bit,
        output noise_flag,
        output false_start,
        output busy
    );

    modport slave (
        output serial_in,
        input  start_detected,
        input  sampling_strobe,
        input  sampled_bit,
        input  noise_flag,
        input  false_start,
        input  busy
    );
endinterface

// File: rtl/rx_sampler.sv
// UART receive front end: synchronises the line, confirms start bits by mid-bit majority
// vote and emits one voted sample strobe per bit, plus a closing strobe at stop-bit end.
module rx_sampler #(
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int CLKS_PER_BIT     = 16
) (
    input  logic          clk,
    input  logic          reset,
    rx_sampler_if.master  bus
);
    localparam int NBITS = INPUT_DATA_WIDTH + 3;
    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CW    = $clog2(CLKS_PER_BIT) + 1;
    localparam int BW    = $clog2(NBITS + 1);

    localparam logic [1:0] HUNT    = 2'd0;
    localparam logic [1:0] CONFIRM = 2'd1;
    localparam logic [1:0] RUN     = 2'd2;
    localparam logic [1:0] TAIL    = 2'd3;

    localparam logic [CW-1:0] CNT_V0    = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_V1    = CW'(HALF);
    localparam logic [CW-1:0] CNT_V2    = CW'(HALF + 1);
    localparam logic [CW-1:0] CNT_RUN0  = CW'(HALF + 2);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_TAIL  = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(NBITS);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);

    logic [1:0]    sync_reg;
    logic          s_d_reg;
    logic [1:0]    state_reg,   state_next;
    logic [CW-1:0] clk_cnt_reg, clk_cnt_next;
    logic [BW-1:0] bit_cnt_reg, bit_cnt_next;
    logic          v0_reg,      v0_next;
    logic          v1_reg,      v1_next;
    logic          strobe_reg,  strobe_next;
    logic          start_reg,   start_next;
    logic          bit_reg,     bit_next;
    logic          noise_reg,   noise_next;
    logic          false_reg,   false_next;
    logic          busy_reg,    busy_next;

    logic line_s;
    logic edge_seen;
    logic vote;
    logic disagree;

    assign line_s    = sync_reg[1];
    assign edge_seen = !line_s && s_d_reg;
    // Third vote sample is the live synchronised line in the deciding cycle.
    assign vote      = (v0_reg & v1_reg) | (v0_reg & line_s) | (v1_reg & line_s);
    assign disagree  = !((v0_reg == v1_reg) && (v1_reg == line_s));

    always_comb begin
        state_next   = state_reg;
        clk_cnt_next = clk_cnt_reg;
        bit_cnt_next = bit_cnt_reg;
        v0_next      = v0_reg;
        v1_next      = v1_reg;
        strobe_next  = 1'b0;
        start_next   = 1'b0;
        noise_next   = 1'b0;
        false_next   = 1'b0;
        bit_next     = bit_reg;
        busy_next    = busy_reg;

        if ((state_reg == CONFIRM) || (state_reg == RUN)) begin
            if (clk_cnt_reg == CNT_V0) v0_next = line_s;
            if (clk_cnt_reg == CNT_V1) v1_next = line_s;
        end

        case (state_reg)
            HUNT: begin
                if (edge_seen) begin
                    state_next   = CONFIRM;
                    clk_cnt_next = CNT_ONE;
                end
            end
            CONFIRM: begin
                clk_cnt_next = clk_cnt_reg + CNT_ONE;
                if (clk_cnt_reg == CNT_V2) begin
                    if (vote) begin
                        false_next   = 1'b1;
                        state_next   = HUNT;
                        clk_cnt_next = '0;
                    end else begin
                        strobe_next  = 1'b1;
                        start_next   = 1'b1;
                        bit_next     = 1'b0;
                        noise_next   = disagree;
                        busy_next    = 1'b1;
                        bit_cnt_next = BIT_ONE;
                        clk_cnt_next = CNT_RUN0;
                        state_next   = RUN;
                    end
                end
            end
            RUN: begin
                clk_cnt_next = (clk_cnt_reg == CNT_LAST) ? '0 : clk_cnt_reg + CNT_ONE;
                if (clk_cnt_reg == CNT_V2) begin
                    strobe_next  = 1'b1;
                    bit_next     = vote;
                    noise_next   = disagree;
                    bit_cnt_next = bit_cnt_reg + BIT_ONE;
                    // Stop bit just sampled: finish out its second half before closing.
                    if ((bit_cnt_reg + BIT_ONE) == BIT_LAST) begin
                        state_next   = TAIL;
                        clk_cnt_next = '0;
                    end
                end
            end
            TAIL: begin
                clk_cnt_next = clk_cnt_reg + CNT_ONE;
                if (clk_cnt_reg == CNT_TAIL) begin
                    strobe_next  = 1'b1;
                    bit_next     = 1'b1;
                    busy_next    = 1'b0;
                    bit_cnt_next = '0;
                    clk_cnt_next = '0;
                    state_next   = HUNT;
                end
            end
            default: begin
                state_next   = HUNT;
                clk_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg    <= 2'b11;
            s_d_reg     <= 1'b1;
            state_reg   <= HUNT;
            clk_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            v0_reg      <= 1'b0;
            v1_reg      <= 1'b0;
            strobe_reg  <= 1'b0;
            start_reg   <= 1'b0;
            bit_reg     <= 1'b1;
            noise_reg   <= 1'b0;
            false_reg   <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[0], bus.serial_in};
            s_d_reg     <= line_s;
            state_reg   <= state_next;
            clk_cnt_reg <= clk_cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            v0_reg      <= v0_next;
            v1_reg      <= v1_next;
            strobe_reg  <= strobe_next;
            start_reg   <= start_next;
            bit_reg     <= bit_next;
            noise_reg   <= noise_next;
            false_reg   <= false_next;
            busy_reg    <= busy_next;
        end
    end

    assign bus.start_detected  = start_reg;
    assign bus.sampling_strobe = strobe_reg;
    assign bus.sampled_bit     = bit_reg;
    assign bus.noise_flag      = noise_reg;
    assign bus.false_start     = false_reg;
    assign bus.busy            = busy_reg;
endmodule

// File: tb/tb_rx_sampler.sv
// Bench for rx_sampler: a frame-timeline model derived from the recorded line checks every
// cycle, and directed per-scenario expectations pin the model with hand-computed values.
module tb_rx_sampler;
    localparam int W         = 8;
    localparam int CPB       = 16;
    localparam int H         = CPB / 2;
    localparam int NB        = W + 3;
    localparam int NS        = NB + 1;
    localparam int START_LAT = H + 4;
    localparam int FINAL_LAT = START_LAT + CPB * (NB - 1) + H;
    localparam int MAXC      = 8192;

    typedef struct {
        int cyc;
        bit b;
        bit st;
        bit nz;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    rx_sampler_if bus();

    rx_sampler #(.INPUT_DATA_WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   cyc = -1;
    bit   line_h [MAXC];
    bit   m_active = 1'b0;
    int   m_f = 0;
    bit   m_hold = 1'b1;
    obs_t slog[$];
    int   fs_log[$];
    int   busy_fall = -1;
    bit   busy_prev = 1'b0;

    logic [5:0] got_v, exp_v;
    bit   rst_now, e_st, e_sb, e_bit, e_nz, e_fs, e_busy;
    int   rel, kb;

    function automatic bit vote_at(input int f, input int k);
        bit a, b, c;
        a = line_h[f + CPB*k + H - 1];
        b = line_h[f + CPB*k + H];
        c = line_h[f + CPB*k + H + 1];
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic bit dis_at(input int f, input int k);
        return !((line_h[f + CPB*k + H - 1] == line_h[f + CPB*k + H]) &&
                 (line_h[f + CPB*k + H] == line_h[f + CPB*k + H + 1]));
    endfunction

    // Per-cycle model: a fall seen while idle starts a frame; every output follows from its timeline.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #2;
        rst_now = !reset;
        if (cyc >= 1 && cyc <= MAXC) line_h[cyc-1] = rst_now ? 1'b1 : bus.serial_in;
        e_st = 0; e_sb = 0; e_bit = m_hold; e_nz = 0; e_fs = 0; e_busy = 0;
        if (rst_now) begin
            m_active = 0;
            e_bit = 1;
        end else if (cyc < MAXC) begin
            if (m_active) begin
                rel = cyc - m_f;
                if (rel == START_LAT) begin
                    if (vote_at(m_f, 0)) begin
                        e_fs = 1;
                        m_active = 0;
                    end else begin
                        e_sb = 1; e_st = 1; e_bit = 0; e_nz = dis_at(m_f, 0); e_busy = 1;
                    end
                end else if (rel > START_LAT) begin
                    e_busy = 1;
                    if (rel == FINAL_LAT) begin
                        e_sb = 1; e_bit = 1; e_busy = 0;
                        m_active = 0;
                    end else if ((rel - START_LAT) % CPB == 0 && (rel - START_LAT) <= CPB*(NB-1)) begin
                        kb = (rel - START_LAT) / CPB;
                        e_sb = 1; e_bit = vote_at(m_f, kb); e_nz = dis_at(m_f, kb);
                    end
                end
            end
            if (!m_active && cyc >= 3 && line_h[cyc-2] == 1'b0 && line_h[cyc-3] == 1'b1) begin
                m_active = 1;
                m_f = cyc - 2;
            end
        end
        m_hold = e_bit;

        got_v = {bus.start_detected, bus.sampling_strobe, bus.sampled_bit,
                 bus.noise_flag, bus.false_start, bus.busy};
        exp_v = {e_st, e_sb, e_bit, e_nz, e_fs, e_busy};
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL outputs cyc=%0d {start,strobe,bit,noise,false,busy} got %b required %b",
                     cyc, got_v, exp_v);
        end

        if (bus.sampling_strobe === 1'b1) begin
            slog.push_back('{cyc: cyc, b: bus.sampled_bit, st: bus.start_detected, nz: bus.noise_flag});
            $display("strobe cyc=%0d bit=%0b start=%0b noise=%0b",
                     cyc, bus.sampled_bit, bus.start_detected, bus.noise_flag);
        end
        if (bus.false_start === 1'b1) begin
            fs_log.push_back(cyc);
            $display("false_start cyc=%0d", cyc);
        end
        if (busy_prev && bus.busy === 1'b0) busy_fall = cyc;
        busy_prev = (bus.busy === 1'b1);
    end

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    task automatic chk_vec(input string name, input logic [NS-1:0] got, input logic [NS-1:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, got, req);
        end
    endtask

    // Field of NS consecutive strobes as a vector, bit i = strobe base+i (0=b,1=noise,2=start).
    function automatic logic [NS-1:0] field_vec(input int base, input int which);
        logic [NS-1:0] v;
        if (slog.size() < base + NS) return {NS{1'bx}};
        for (int i = 0; i < NS; i++)
            v[i] = (which == 0) ? slog[base+i].b : (which == 1) ? slog[base+i].nz : slog[base+i].st;
        return v;
    endfunction

    function automatic int log_cyc(input int idx);
        if (idx >= slog.size()) return -1;
        return slog[idx].cyc;
    endfunction

    task automatic tick(input bit v);
        @(negedge clk);
        bus.serial_in = v;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b1);
    endtask

    task automatic send_frame(input logic [W-1:0] d, input bit stop_v, input int stop_len,
                              input int spike_idx, input int max_ticks, output int f);
        logic [NB-1:0] fr;
        int n;
        fr = {stop_v, ^d, d, 1'b0};
        n = 0;
        f = -1;
        for (int b = 0; b < NB; b++) begin
            for (int t = 0; t < ((b == NB-1) ? stop_len : CPB); t++) begin
                if (n == max_ticks) return;
                tick((b == spike_idx && t == H) ? ~fr[b] : fr[b]);
                if (n == 0) f = cyc;
                n++;
            end
        end
    endtask

    initial begin
        int f1, f2, base, nfs;
        bus.serial_in = 1'b1;

        // Reset state
        idle(5);
        chk("reset sampled_bit", bus.sampled_bit, 1);
        chk("reset busy", bus.busy, 0);
        chk("reset strobe", bus.sampling_strobe, 0);
        reset = 1'b1;
        idle(5);

        // 1: clean 0x55, even parity
        base = slog.size();
        send_frame(8'h55, 1'b1, CPB, -1, 1000, f1);
        idle(20);
        chk("t1 strobe count", slog.size() - base, NS);
        chk("t1 start latency", log_cyc(base) - f1, 12);
        chk_vec("t1 start flags", field_vec(base, 2), 12'h001);
        chk_vec("t1 bits", field_vec(base, 0), 12'hCAA);
        chk_vec("t1 noise", field_vec(base, 1), 12'h000);
        chk("t1 busy fall after stop strobe", busy_fall - log_cyc(base + 10), 8);
        chk("t1 final strobe gap", log_cyc(base + 11) - log_cyc(base + 10), 8);

        // 2: 3-cycle glitch
        base = slog.size();
        nfs = fs_log.size();
        tick(1'b0);
        f1 = cyc;
        tick(1'b0);
        tick(1'b0);
        idle(30);
        chk("t2 false_start count", fs_log.size() - nfs, 1);
        chk("t2 false_start latency", (fs_log.size() > nfs) ? fs_log[nfs] - f1 : -1, 12);
        chk("t2 no strobes", slog.size() - base, 0);

        // 3: 0xA3 with a spike in the middle of data bit 3
        base = slog.size();
        send_frame(8'hA3, 1'b1, CPB, 4, 1000, f1);
        idle(20);
        chk_vec("t3 bits", field_vec(base, 0), 12'hD46);
        chk_vec("t3 noise", field_vec(base, 1), 12'h010);

        // 4: back-to-back, second edge lands when the closing strobe issues
        base = slog.size();
        send_frame(8'h0F, 1'b1, CPB + 2, -1, 1000, f1);
        send_frame(8'h96, 1'b1, CPB, -1, 1000, f2);
        idle(20);
        chk("t4 strobe count", slog.size() - base, 2 * NS);
        chk("t4 final strobe at edge", log_cyc(base + 11) - f2, 2);
        chk("t4 second start latency", log_cyc(base + 12) - f2, 12);
        chk_vec("t4 frame1 bits", field_vec(base, 0), 12'hC1E);
        chk_vec("t4 frame2 bits", field_vec(base + NS, 0), 12'hD2C);
        chk_vec("t4 frame2 start flags", field_vec(base + NS, 2), 12'h001);

        // 5: reset during data bit 5
        base = slog.size();
        send_frame(8'h55, 1'b1, CPB, -1, 6*CPB + H, f1);
        chk("t5 strobes before reset", slog.size() - base, 6);
        chk("t5 busy before reset", bus.busy, 1);
        reset = 1'b0;
        bus.serial_in = 1'b1;
        #1;
        chk("t5 busy cleared", bus.busy, 0);
        chk("t5 sampled_bit forced", bus.sampled_bit, 1);
        chk("t5 strobe cleared", bus.sampling_strobe, 0);
        idle(4);
        reset = 1'b1;
        idle(30);
        chk("t5 no strobes after abort", slog.size() - base, 6);
        base = slog.size();
        send_frame(8'h3C, 1'b1, CPB, -1, 1000, f1);
        idle(20);
        chk("t5 strobe count after release", slog.size() - base, NS);
        chk("t5 start latency", log_cyc(base) - f1, 12);
        chk_vec("t5 bits", field_vec(base, 0), 12'hC78);

        // 6: stop bit held low, line stays low, then a fresh frame
        base = slog.size();
        nfs = fs_log.size();
        send_frame(8'h55, 1'b0, CPB, -1, 1000, f1);
        repeat (40) tick(1'b0);
        idle(20);
        chk("t6 strobe count", slog.size() - base, NS);
        chk_vec("t6 bits", field_vec(base, 0), 12'h8AA);
        chk("t6 no false_start", fs_log.size() - nfs, 0);
        chk("t6 busy fall after stop strobe", busy_fall - log_cyc(base + 10), 8);
        base = slog.size();
        send_frame(8'h55, 1'b1, CPB, -1, 1000, f1);
        idle(20);
        chk("t6 fresh frame start latency", log_cyc(base) - f1, 12);
        chk_vec("t6 fresh frame bits", field_vec(base, 0), 12'hCAA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
